// File: rtl/serializer_pkg.sv
// Shared types and helpers for bit_serializer.
// Holds the FSM state enum, the default word width and the head-bit position helper.
// Optional feature macro: BIT_SERIALIZER_PARITY_EN (PARITY state is only used when it is defined).
package serializer_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  // Bit position that leaves the shift register first.
  function automatic int unsigned head_index(input int unsigned width, input bit lsb_first);
    return lsb_first ? 0 : width - 1;
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bus of bit_serializer.
// master: word producer (drives in_valid/in_word, observes everything else).
// slave : serializer (drives in_ready, data, data_valid, frame_done).
interface bit_serializer_if
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_word;
  logic             data;
  logic             data_valid;
  logic             frame_done;

  modport master (
    output in_valid, in_word,
    input  in_ready, data, data_valid, frame_done
  );

  modport slave (
    input  in_valid, in_word,
    output in_ready, data, data_valid, frame_done
  );

endinterface

// File: rtl/ser_shift_reg.sv
// WIDTH-bit load/shift register for bit_serializer.
// Ports: clk, rst (sync, active-high), load (takes load_word, wins over shift),
//        shift (moves the next bit to the head), load_word, head (current outgoing bit).
// LSB_FIRST selects shift direction and head position.
module ser_shift_reg
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_word,
  output logic             head
);

  localparam int unsigned HEAD_IDX = head_index(WIDTH, LSB_FIRST);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] shifted_c;

  // Vacated positions fill with zero; they are never sent before a reload.
  if (LSB_FIRST) begin : g_lsb
    assign shifted_c = {1'b0, sr_q[WIDTH-1:1]};
  end else begin : g_msb
    assign shifted_c = {sr_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= load_word;
    end else if (shift) begin
      sr_q <= shifted_c;
    end
  end

  assign head = sr_q[HEAD_IDX];

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on a valid/ready
// handshake and emits one bit per clock on data, words back to back.
// Ports: clk, rst (sync, active-high), bus (bit_serializer_if.slave):
//        in_valid/in_ready/in_word in, data/data_valid/frame_done out.
// Macro BIT_SERIALIZER_PARITY_EN appends one even-parity bit per word.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  bit_serializer_if.slave       bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_c;
  logic             head_c;
  logic             load_c;
  logic             shift_c;
  logic             ready_c;
  logic             data_c;
  logic             valid_c;
  logic             done_c;

`ifdef BIT_SERIALIZER_PARITY_EN
  logic             parity_q;
`endif

  assign last_c = (cnt_q == CNT_LAST);

  ser_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .shift     (shift_c),
    .load_word (bus.in_word),
    .head      (head_c)
  );

  // State and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BIT_SERIALIZER_PARITY_EN
  // Even parity of the word is captured at acceptance, before in_word may change.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (load_c) begin
      parity_q <= ^bus.in_word;
    end
  end
`endif

  // Next state, handshake and output decode from registered state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    shift_c = 1'b0;
    ready_c = 1'b0;
    data_c  = 1'b0;
    valid_c = 1'b0;
    done_c  = 1'b0;

    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
      end
      SHIFT: begin
        data_c  = head_c;
        valid_c = 1'b1;
        shift_c = 1'b1;
        if (!last_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
          ready_c = 1'b1;
          done_c  = 1'b1;
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: begin
        data_c  = parity_q;
        valid_c = 1'b1;
        done_c  = 1'b1;
        ready_c = 1'b1;
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst) begin
      ready_c = 1'b0;
    end

    // A new word overrides the end-of-frame return to IDLE, giving gapless streaming.
    if (bus.in_valid && ready_c) begin
      state_d = SHIFT;
      cnt_d   = '0;
      load_c  = 1'b1;
    end
  end

  assign bus.in_ready   = ready_c;
  assign bus.data       = data_c;
  assign bus.data_valid = valid_c;
  assign bus.frame_done = done_c;

endmodule
